// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator and instruction memory.
// Carries the group PC, its valid lanes, the AdEL flag and the valid/ready pair.
// The generator drives the request and memory returns ready.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int FETCH_N = 1
);
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  pc;
    logic [FETCH_N-1:0] lane_mask;
    logic               excp_adel;

    modport master (
        output req_valid,
        output pc,
        output lane_mask,
        output excp_adel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  pc,
        input  lane_mask,
        input  excp_adel,
        output req_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: holds fetch PC, issues aligned group requests, applies flush/branch redirects.
// Latency: redirect or accepted request in cycle n is reflected on pc in cycle n+1; first request right after reset.
// Backpressure: pc holds while stalled or not accepted; a branch seen under stall is buffered until stall drops.
module pc_gen #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          FETCH_N  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    input  logic              i_br_valid,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_redir_pend,
    pc_gen_if.master          m_fetch
);
    // Fetch group size in bytes and lanes-index width.
    localparam int L = $clog2(FETCH_N);
    localparam int G = FETCH_N * 4;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_pend_vld;
    logic [ADDR_W-1:0]  r_pend_addr;

    logic               w_adel;
    logic               w_req_vld;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_seq_next;
    logic [FETCH_N-1:0] w_lane_mask;

    // Request is withheld on a misaligned PC and while a buffered redirect makes the PC stale.
    assign w_adel     = (r_pc[1:0] != 2'b00);
    assign w_req_vld  = !w_adel && !r_pend_vld;
    assign w_accept   = w_req_vld && m_fetch.req_ready && !i_stall;
    // Next group starts at the following G-aligned address; natural ADDR_W wrap.
    assign w_seq_next = (r_pc & ~ADDR_W'(G - 1)) + ADDR_W'(G);

    generate
        if (FETCH_N == 1) begin : g_single
            assign w_lane_mask = 1'b1;
        end else begin : g_multi
            logic [L-1:0] w_lane_idx;
            assign w_lane_idx = r_pc[L+1:2];
            // Lanes before the entry word of the group are not part of this fetch.
            always_comb begin
                w_lane_mask = '0;
                for (int i = 0; i < FETCH_N; i++) begin
                    w_lane_mask[i] = (i >= int'(w_lane_idx));
                end
            end
        end
    endgenerate

    // PC / pending-redirect update in fixed priority: flush, branch, buffered branch, pending, sequential.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= ADDR_W'(RESET_PC);
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
        end else if (i_flush) begin
            r_pc       <= i_flush_pc;
            r_pend_vld <= 1'b0;
        end else if (i_br_valid && !i_stall) begin
            r_pc       <= i_br_target;
            r_pend_vld <= 1'b0;
        end else if (i_br_valid && i_stall) begin
            r_pend_addr <= i_br_target;
            r_pend_vld  <= 1'b1;
        end else if (r_pend_vld && !i_stall) begin
            r_pc       <= r_pend_addr;
            r_pend_vld <= 1'b0;
        end else if (w_accept) begin
            r_pc <= w_seq_next;
        end
    end

    assign m_fetch.req_valid = w_req_vld;
    assign m_fetch.pc        = r_pc;
    assign m_fetch.lane_mask = w_lane_mask;
    assign m_fetch.excp_adel = w_adel;
    assign o_redir_pend      = r_pend_vld;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: single-lane and four-lane instances share stimulus.
// Each is compared against a rule-level reference model every checked cycle.
// Directed scenarios also check fixed expected addresses.
module tb_pc_gen;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        req_ready;
    logic        redir1;
    logic        redir4;

    int n_checks;
    int n_fail;

    // Reference model state, index 0 = FETCH_N 1, index 1 = FETCH_N 4.
    logic [31:0] m_pc   [2];
    logic        m_pend [2];
    logic [31:0] m_paddr[2];

    pc_gen_if #(.ADDR_W(32), .FETCH_N(1)) if1 ();
    pc_gen_if #(.ADDR_W(32), .FETCH_N(4)) if4 ();

    assign if1.req_ready = req_ready;
    assign if4.req_ready = req_ready;

    pc_gen #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000), .FETCH_N(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_flush_pc(flush_pc),
        .i_br_valid(br_valid), .i_br_target(br_target), .o_redir_pend(redir1), .m_fetch(if1)
    );

    pc_gen #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000), .FETCH_N(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_flush_pc(flush_pc),
        .i_br_valid(br_valid), .i_br_target(br_target), .o_redir_pend(redir4), .m_fetch(if4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lanes_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = 32'hBFC0_0000;
            m_pend[k]  = 1'b0;
            m_paddr[k] = 32'h0;
        end
    endtask

    // Apply one clock edge of the redirect/fetch rules to the model.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          gbytes;
            logic        rv;
            logic        acc;
            gbytes = 4 * lanes_of(k);
            rv  = (m_pc[k] % 4 == 0) && !m_pend[k];
            acc = rv && req_ready && !stall;
            if (flush) begin
                m_pc[k] = flush_pc; m_pend[k] = 1'b0;
            end else if (br_valid && !stall) begin
                m_pc[k] = br_target; m_pend[k] = 1'b0;
            end else if (br_valid && stall) begin
                m_paddr[k] = br_target; m_pend[k] = 1'b1;
            end else if (m_pend[k] && !stall) begin
                m_pc[k] = m_paddr[k]; m_pend[k] = 1'b0;
            end else if (acc) begin
                m_pc[k] = m_pc[k] - (m_pc[k] % gbytes) + 32'(gbytes);
            end
        end
    endtask

    // Expected {pc, lane_mask(4), excp_adel, req_valid, redir_pend}.
    function automatic logic [38:0] exp_vec(int k);
        int          n;
        int          off;
        logic [31:0] p;
        logic [3:0]  mask;
        logic        adel;
        n    = lanes_of(k);
        p    = m_pc[k];
        off  = int'(p % (4 * n)) / 4;
        mask = 4'((1 << n) - 1) & ~4'((1 << off) - 1);
        adel = (p % 4) != 0;
        return {p, mask, adel, !adel && !m_pend[k], m_pend[k]};
    endfunction

    function automatic logic [38:0] obs_vec(int k);
        if (k == 0) return {if1.pc, 3'b000, if1.lane_mask, if1.excp_adel, if1.req_valid, redir1};
        return {if4.pc, if4.lane_mask, if4.excp_adel, if4.req_valid, redir4};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; flush_pc = '0; br_valid = 0; br_target = '0; req_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++; $display("FAIL reset_state dut%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        @(negedge clk);
        rst = 0;
        #1;
        n_checks++;
        if (if1.pc !== 32'hBFC0_0000 || if1.req_valid !== 1'b1 || if4.lane_mask !== 4'b1111) begin
            n_fail++; $display("FAIL first_req got pc=%h rv=%b mask4=%b want pc=bfc00000 rv=1 mask4=1111",
                               if1.pc, if1.req_valid, if4.lane_mask);
        end
        step();
        n_checks++;
        if (if1.pc !== 32'hBFC0_0004 || if4.pc !== 32'hBFC0_0010) begin
            n_fail++; $display("FAIL seq1 got pc1=%h pc4=%h want bfc00004 bfc00010", if1.pc, if4.pc);
        end
        step();
        n_checks++;
        if (if1.pc !== 32'hBFC0_0008 || if1.lane_mask !== 1'b1 || if1.excp_adel !== 1'b0) begin
            n_fail++; $display("FAIL seq2 got pc1=%h mask=%b adel=%b want bfc00008 1 0",
                               if1.pc, if1.lane_mask, if1.excp_adel);
        end
    endtask

    task automatic test_branch_fetch4();
        br_valid = 1; br_target = 32'h1008;
        step();
        br_valid = 0;
        n_checks++;
        if (if4.pc !== 32'h1008 || if4.lane_mask !== 4'b1100 || if4.req_valid !== 1'b1) begin
            n_fail++; $display("FAIL br_fetch4 got pc=%h mask=%b rv=%b want 00001008 1100 1",
                               if4.pc, if4.lane_mask, if4.req_valid);
        end
        step();
        n_checks++;
        if (if4.pc !== 32'h1010 || if4.lane_mask !== 4'b1111 || if1.pc !== 32'h100C) begin
            n_fail++; $display("FAIL br_fetch4_next got pc4=%h mask=%b pc1=%h want 00001010 1111 0000100c",
                               if4.pc, if4.lane_mask, if1.pc);
        end
    endtask

    task automatic test_stalled_branch();
        logic [31:0] held;
        held = if1.pc;
        stall = 1; br_valid = 1; br_target = 32'h2000;
        step();
        br_valid = 0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (if1.pc !== held || redir1 !== 1'b1 || if1.req_valid !== 1'b0 || redir4 !== 1'b1) begin
                n_fail++; $display("FAIL stall_pend cyc%0d got pc=%h rp=%b rv=%b want pc=%h rp=1 rv=0",
                                   c, if1.pc, redir1, if1.req_valid, held);
            end
            step();
        end
        stall = 0;
        step();
        n_checks++;
        if (if1.pc !== 32'h2000 || redir1 !== 1'b0 || if4.pc !== 32'h2000) begin
            n_fail++; $display("FAIL stall_release got pc1=%h pc4=%h rp=%b want 00002000 00002000 0",
                               if1.pc, if4.pc, redir1);
        end
    endtask

    task automatic test_flush_priority();
        stall = 1; br_valid = 1; br_target = 32'h5000;
        step();
        flush = 1; flush_pc = 32'h8000_0180; br_target = 32'h3000;
        step();
        flush = 0; br_valid = 0; stall = 0;
        n_checks++;
        if (if1.pc !== 32'h8000_0180 || redir1 !== 1'b0 || if4.pc !== 32'h8000_0180 || redir4 !== 1'b0) begin
            n_fail++; $display("FAIL flush_prio got pc1=%h rp1=%b pc4=%h rp4=%b want 80000180 0",
                               if1.pc, redir1, if4.pc, redir4);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++; $display("FAIL flush_model dut%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_misaligned();
        br_valid = 1; br_target = 32'h4002;
        step();
        br_valid = 0; req_ready = 1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (if1.pc !== 32'h4002 || if1.excp_adel !== 1'b1 || if1.req_valid !== 1'b0 ||
                if4.pc !== 32'h4002 || if4.req_valid !== 1'b0) begin
                n_fail++; $display("FAIL misalign_hold cyc%0d got pc=%h adel=%b rv=%b want 00004002 1 0",
                                   c, if1.pc, if1.excp_adel, if1.req_valid);
            end
            step();
        end
        flush = 1; flush_pc = 32'h8000_0180;
        step();
        flush = 0;
        n_checks++;
        if (if1.excp_adel !== 1'b0 || if1.pc !== 32'h8000_0180 || if4.excp_adel !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear got pc=%h adel=%b want 80000180 0", if1.pc, if1.excp_adel);
        end
    endtask

    task automatic test_wrap();
        flush = 1; flush_pc = 32'hFFFF_FFFC;
        step();
        flush = 0; req_ready = 0;
        n_checks++;
        if (if4.lane_mask !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_mask got=%b want 1000", if4.lane_mask);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (if1.pc !== 32'hFFFF_FFFC || if4.pc !== 32'hFFFF_FFFC) begin
                n_fail++; $display("FAIL wrap_hold cyc%0d got pc1=%h pc4=%h want fffffffc", c, if1.pc, if4.pc);
            end
        end
        req_ready = 1;
        step();
        n_checks++;
        if (if1.pc !== 32'h0 || if4.pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_accept got pc1=%h pc4=%h want 00000000", if1.pc, if4.pc);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall     = ($urandom % 4) == 0;
            flush     = ($urandom % 16) == 0;
            br_valid  = ($urandom % 6) == 0;
            req_ready = ($urandom % 4) != 0;
            flush_pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            br_target = {$urandom} & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            step();
            if (($urandom % 64) == 0) begin
                rst = 1;
                model_reset();
                #1;
                rst = 0;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++; $display("FAIL random cyc%0d dut%0d got=%h want=%h", c, k, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_branch_fetch4();
        test_stalled_branch();
        test_flush_priority();
        test_misaligned();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the CPU front end; successor to the single-issue program counter. Holds the fetch PC, issues aligned fetch-group requests to instruction memory over a valid/ready handshake, applies flush and branch redirects with fixed priority, and buffers a branch redirect that arrives while the front end is stalled so it is never lost. Flags instruction-address-load errors (AdEL) and stops fetching at a misaligned PC.

## Interface
- ADDR_W, 32, address width in bits (≥ 8)
- RESET_PC, 32'hBFC0_0000, PC loaded on reset (low ADDR_W bits used)
- FETCH_N, 1, instructions per fetch group; legal values 1, 2, 4
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  downstream stall; PC must not advance
- flush  in  1  exception/ERET redirect, highest priority
- flush_pc  in  ADDR_W  flush target
- br_valid  in  1  resolved branch/jump redirect
- br_target  in  ADDR_W  branch target
- req_valid  out  1  fetch request valid
- req_ready  in  1  instruction memory accepts request
- pc  out  ADDR_W  current fetch PC (first valid instruction of group)
- lane_mask  out  FETCH_N  valid instruction lanes in the group
- excp_adel  out  1  PC misaligned (pc[1:0] != 0)
- redir_pend  out  1  a buffered branch redirect is waiting

## Operation
- State: pc register, pend_valid flag, pend_addr register (ADDR_W).
- G = FETCH_N*4 bytes; L = log2(FETCH_N). Sequential next = (pc with low log2(G) bits cleared) + G, wraps modulo 2^ADDR_W.
- lane_mask bit i = 1 iff i ≥ pc[L+1:2]; FETCH_N=1 → lane_mask = 1. Combinational from pc.
- excp_adel = (pc[1:0] != 0), combinational. req_valid = !excp_adel && !pend_valid. (A pending redirect makes the current PC stale, so no request is issued from it.)
- accept = req_valid && req_ready && !stall.
- Next-state priority at each rising edge:
  1. flush: pc ← flush_pc; pend_valid ← 0 (overrides everything, including simultaneous br_valid and pending redirect).
  2. br_valid && !stall: pc ← br_target; pend_valid ← 0.
  3. br_valid && stall: pend_addr ← br_target; pend_valid ← 1 (overwrites an older pending entry).
  4. pend_valid && !stall: pc ← pend_addr; pend_valid ← 0.
  5. accept: pc ← sequential next.
  6. otherwise hold.
- Misaligned PC: pc holds, no requests, excp_adel stays 1 until flush or branch redirect replaces pc.
- redir_pend = pend_valid.

## Timing
- Reset (async assert): pc = RESET_PC, pend_valid = 0, pend_addr = 0. Outputs during reset: pc = RESET_PC, lane_mask per RESET_PC, redir_pend = 0, excp_adel = (RESET_PC[1:0] != 0), req_valid = !excp_adel.
- First request is valid in the first cycle after rst deasserts; no bubble.
- Redirect latency: flush or unstalled branch in cycle n → new pc and req_valid in cycle n+1.
- Stalled branch in cycle n → redir_pend=1 from n+1; first unstalled edge m loads pc; new pc visible m+1.
- req_valid may drop without acceptance (redirect/pending); memory must not rely on request persistence across redirects. Same pc is re-presented until accepted.
- Reset mid-stall or mid-pending: pending redirect discarded.

## Test plan
- Reset, FETCH_N=1, req_ready=1, no stall: pc = BFC00000, BFC00004, BFC00008 on consecutive cycles; lane_mask=1; excp_adel=0.
- FETCH_N=4, br_target=0x1008: next pc=0x1008, lane_mask=4'b1100; after accept pc=0x1010, lane_mask=4'b1111.
- stall=1 with br_valid, br_target=0x2000 for one cycle, stall held 3 more cycles: pc unchanged, redir_pend=1, req_valid=0; stall drops → pc=0x2000 next cycle, redir_pend=0.
- Same cycle flush (flush_pc=0x80000180) and br_valid (0x3000), also with a pending redirect: pc=0x80000180, redir_pend=0.
- br_target=0x4002: pc=0x4002, excp_adel=1, req_valid=0, pc holds for 5 cycles despite req_ready=1; flush to 0x80000180 clears excp_adel.
- req_ready=0 for 4 cycles, ADDR_W=32, pc=0xFFFFFFFC: pc holds; on accept pc wraps to 0x00000000.
